hni_rxdat: RTL
==============

Name: hni_rxdat

Overview:
HNI link-layer receiver for the CHI-E DAT channel. It is the credit-granting end of the DAT link-layer credit protocol.
- Issues L-credits to the remote transmitter via rxdatlcrdv.
- Captures incoming DAT flits into a credit-sized FIFO.
- Presents flits in order to the HNI data buffer with a valid/ready handshake.
- Returns each credit only after the flit's FIFO entry is freed.
It sits between hni_link (RX side) and hni_data_buffer.

Parameters:
RXDAT_FIFO_DEPTH, 4, FIFO entries; equals the maximum credits outstanding; legal range 1..15.
DAT_FLIT_WIDTH, `CHIE_DAT_FLIT_WIDTH, DAT flit width in bits.
CNT_WIDTH, 4, width of the FIFO occupancy counter and the outstanding-credit counter.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
rxdat_link_active  input  1  from hni_link; 1 = link in RUN state, credit issue permitted
rxdatflitv  input  1  flit valid from link
rxdatflit  input  DAT_FLIT_WIDTH  flit from link
rxdatflitpend  input  1  flit pending from link; ignored
rxdatlcrdv  output  1  L-credit grant to link, registered, one credit per cycle
rxdat_dbf_valid_s1  output  1  FIFO head valid to data buffer
rxdat_dbf_flit  output  DAT_FLIT_WIDTH  FIFO head flit
dbf_rxdat_rdy_s1  input  1  data buffer accepts head this cycle
rxdat_crd_err  output  1  sticky protocol error (optional feature)

Behaviour:
Reset and state
- Reset is clk / rst, asynchronous, active-high.
- On reset: rxdatlcrdv=0, all FIFO storage=0, rd/wr pointers=0, fifo_cnt_q=0, crd_out_q=0, rxdat_crd_err=0.
- rxdat_dbf_valid_s1=0 and rxdat_dbf_flit=0 during and after reset.

Credit accounting
- crd_out_q counts credits granted but not yet consumed by a flit.
- Invariant: fifo_cnt_q + crd_out_q <= RXDAT_FIFO_DEPTH.
- Issue condition: crd_issue = rxdat_link_active & (fifo_cnt_q + crd_out_q < RXDAT_FIFO_DEPTH). It is evaluated on registered values only.
- rxdatlcrdv <= crd_issue every cycle. Consequences:
  - Credit pulses are one cycle wide.
  - Back-to-back credits are allowed.
  - The first credit appears one cycle after reset release.
- crd_out_q next-state rules:
  - +1 on crd_issue.
  - -1 on an accepted flit.
  - Both in the same cycle: hold.
- The compare uses CNT_WIDTH+1 bits; no overflow or wrap is possible.

Flit receive
- A flit is accepted when rxdatflitv=1 and crd_out_q != 0.
- An accepted flit is written at wr_ptr.
- wr_ptr increments and wraps from RXDAT_FIFO_DEPTH-1 to 0 (non-power-of-2 depths wrap explicitly).
- A flit arriving with crd_out_q == 0 is a protocol violation:
  - The flit is dropped.
  - fifo_cnt_q and crd_out_q are unchanged.
  - The FIFO is never overwritten.

Data buffer output
- rxdat_dbf_valid_s1 = (fifo_cnt_q != 0).
- rxdat_dbf_flit = storage[rd_ptr], combinational from registers. It is zero-masked when not valid.
- A pop occurs on valid & dbf_rxdat_rdy_s1; rd_ptr increments with the same wrap rule.
- Latency:
  - A flit accepted at edge E is visible at the output after E; there is no same-cycle bypass.
  - A pop at edge E frees the entry at E. rxdatlcrdv can assert after edge E+1.
- fifo_cnt_q rules:
  - +1 on push.
  - -1 on pop.
  - Simultaneous push and pop: hold.
- Output ordering is strict arrival order.

Link inactive
- With rxdat_link_active=0, no new credits are issued.
- Outstanding credits remain valid, and flits against them are still accepted.
- Credits are not returned or cancelled by this block.

Reset mid-operation
- All FIFO contents and counters are cleared immediately.
- Credit issue restarts from zero after rst deasserts.

Optional Feature:
Macro: HNI_RXDAT_CRD_CHECK_EN.
- Defined:
  - rxdat_crd_err is a register.
  - It is set to 1 on any cycle with rxdatflitv=1 and crd_out_q==0.
  - It is sticky until rst.
  - Flit drop behaviour is unchanged.
- Not defined: rxdat_crd_err is tied to 0 and no checking logic is built.

Test Plan:
1. Credit ramp: depth=4, release rst with link_active=1 -> rxdatlcrdv high cycles 1..4, then low; crd_out_q=4.
2. Single flit: after ramp, drive flitv with data 0xA5, rdy=1 ->
   - valid=1 with flit 0xA5 on the next cycle, popped that cycle;
   - exactly one rxdatlcrdv pulse follows two cycles after the pop edge.
3. Backpressure/full: rdy=0, send 4 flits -> fifo_cnt_q=4, no credits issued. Assert rdy for 1 cycle -> first flit popped, then exactly one credit.
4. Wrap and order: depth=3, stream 10 flits 0..9 with rdy=1 against credits -> output sequence 0..9, no loss; rxdatlcrdv never causes crd_out_q > 3.
5. Link inactive + violation: drop link_active after ramp, send 5 flits ->
   - 4 stored, 5th dropped, no new credits;
   - rxdat_crd_err=1 with HNI_RXDAT_CRD_CHECK_EN, 0 without.
6. Reset mid-stream: assert rst with 2 flits buffered -> valid=0, lcrdv=0, err=0 immediately; after release, credit ramp of test 1 repeats.

Source files
------------

// File: rtl/hni_rxdat.sv
// hni_rxdat: CHI-E DAT link-layer receiver. Grants L-credits, buffers flits, feeds the data buffer in order.
// Optional credit-violation error flag is built only when HNI_RXDAT_CRD_CHECK_EN is defined.
`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 8
`endif

module hni_rxdat #(
    parameter int RXDAT_FIFO_DEPTH = 4,
    parameter int DAT_FLIT_WIDTH   = `CHIE_DAT_FLIT_WIDTH,
    parameter int CNT_WIDTH        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxdat_link_active,
    input  logic                      rxdatflitv,
    input  logic [DAT_FLIT_WIDTH-1:0] rxdatflit,
    input  logic                      rxdatflitpend,
    output logic                      rxdatlcrdv,
    output logic                      rxdat_dbf_valid_s1,
    output logic [DAT_FLIT_WIDTH-1:0] rxdat_dbf_flit,
    input  logic                      dbf_rxdat_rdy_s1,
    output logic                      rxdat_crd_err
);

    localparam int                  PTR_W      = (RXDAT_FIFO_DEPTH > 1) ? $clog2(RXDAT_FIFO_DEPTH) : 1;
    localparam logic [CNT_WIDTH:0]  DEPTH_C    = (CNT_WIDTH+1)'(RXDAT_FIFO_DEPTH);
    localparam logic [PTR_W-1:0]    LAST_PTR_C = PTR_W'(RXDAT_FIFO_DEPTH - 1);

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR_C) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    logic [DAT_FLIT_WIDTH-1:0] mem_q [RXDAT_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]      fifo_cnt_q, fifo_cnt_d, crd_out_q, crd_out_d;
    logic                      lcrdv_q;
    logic [CNT_WIDTH:0]        crd_sum_s;
    logic                      crd_issue_s, flit_acc_s, head_vld_s, pop_s;
    logic                      unused_flitpend_s;

    assign unused_flitpend_s = rxdatflitpend;

    // Handshake decode; credit issue looks only at registered counters.
    always_comb begin
        crd_sum_s   = {1'b0, fifo_cnt_q} + {1'b0, crd_out_q};
        crd_issue_s = rxdat_link_active & (crd_sum_s < DEPTH_C);
        flit_acc_s  = rxdatflitv & (crd_out_q != '0);
        head_vld_s  = (fifo_cnt_q != '0);
        pop_s       = head_vld_s & dbf_rxdat_rdy_s1;
    end

    // Next-state for pointers and both counters.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        crd_out_d  = crd_out_q;
        if (flit_acc_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({flit_acc_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_WIDTH'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_WIDTH'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({crd_issue_s, flit_acc_s})
            2'b10:   crd_out_d = crd_out_q + CNT_WIDTH'(1);
            2'b01:   crd_out_d = crd_out_q - CNT_WIDTH'(1);
            default: crd_out_d = crd_out_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            crd_out_q  <= '0;
            lcrdv_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            crd_out_q  <= crd_out_d;
            lcrdv_q    <= crd_issue_s;
        end
    end

    // Flit storage; dropped (uncredited) flits never reach it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RXDAT_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flit_acc_s) begin
            mem_q[wr_ptr_q] <= rxdatflit;
        end
    end

    assign rxdatlcrdv         = lcrdv_q;
    assign rxdat_dbf_valid_s1 = head_vld_s;
    assign rxdat_dbf_flit     = head_vld_s ? mem_q[rd_ptr_q] : '0;

`ifdef HNI_RXDAT_CRD_CHECK_EN
    logic crd_err_q;

    // Sticky flag for a flit arriving without an outstanding credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crd_err_q <= 1'b0;
        end else if (rxdatflitv && (crd_out_q == '0)) begin
            crd_err_q <= 1'b1;
        end
    end

    assign rxdat_crd_err = crd_err_q;
`else
    assign rxdat_crd_err = 1'b0;
`endif

endmodule
